// File: rtl/load_align_unit_if.sv
// ---------------------------------------------------------------------------
// load_align_unit_if
// Groups the request, memory-read and response channels of load_align_unit.
//   master : requester / memory side (drives requests, resp_ready, mem_rdata)
//   slave  : the aligner itself
// Request : req_valid, req_ready, req_addr, req_size, req_unsigned, req_tag
// Memory  : mem_re, mem_addr, mem_rdata (rdata valid one cycle after mem_re)
// Response: resp_valid, resp_ready, resp_data, resp_tag, resp_err, resp_misal
// ---------------------------------------------------------------------------
interface load_align_unit_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [XLEN-1:0]       mem_rdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_err;
    logic                  resp_misal;

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, req_tag,
        output resp_ready, mem_rdata,
        input  req_ready, mem_re, mem_addr,
        input  resp_valid, resp_data, resp_tag, resp_err, resp_misal
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, req_tag,
        input  resp_ready, mem_rdata,
        output req_ready, mem_re, mem_addr,
        output resp_valid, resp_data, resp_tag, resp_err, resp_misal
    );
endinterface

// File: rtl/load_align_unit.sv
// ---------------------------------------------------------------------------
// load_align_unit
// Load-data aligner between the memory stage and a synchronous-read memory.
// Takes one load at a time, reads one word (two if the access straddles a
// word boundary), extracts the addressed bytes little-endian and zero/sign
// extends them to XLEN, then returns the result over valid/ready.
//
// Ports: clk, rst (synchronous, active high), bus (load_align_unit_if.slave)
//   carrying the request, memory-read and response channels.
//
// Build option: LOAD_ALIGN_SPLIT_EN
//   defined   - straddling loads are served with two consecutive reads
//   undefined - straddling loads return resp_misal=1 without reading memory
// ---------------------------------------------------------------------------
module load_align_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    load_align_unit_if.slave     bus
);
    localparam int W    = XLEN / 8;
    localparam int OFFW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
`ifdef LOAD_ALIGN_SPLIT_EN
        ISSUE1 = 3'd2,
`endif
        CAPT   = 3'd3,
        ERR    = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t                state_r, state_nx_s;

    logic [OFFW-1:0]       off_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic                  err_r;
`ifdef LOAD_ALIGN_SPLIT_EN
    logic                  split_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [XLEN-1:0]       lo_r;
`endif

    logic                  mem_re_r, mem_re_nx_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nx_s;

    logic                  resp_valid_r, resp_err_r, resp_misal_r;
    logic [XLEN-1:0]       resp_data_r;
    logic [TAG_WIDTH-1:0]  resp_tag_r;

    logic                  accept_s, req_illegal_s, req_split_s;
    logic [OFFW-1:0]       req_off_s;
    logic [3:0]            req_nbytes_s;
    logic [4:0]            req_span_s;
    logic [ADDR_WIDTH-1:0] req_base_s;

    logic [2*XLEN-1:0]     wide_s;
    logic [XLEN-1:0]       low_s, mask_s, result_s;
    logic                  sign_s;

    assign bus.req_ready  = (state_r == IDLE) && !rst;
    assign bus.mem_re     = mem_re_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_tag   = resp_tag_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_misal = resp_misal_r;

    // Decode the offered request: offset, footprint, straddle and legality
    always_comb begin
        accept_s      = bus.req_valid && (state_r == IDLE) && !rst;
        req_off_s     = bus.req_addr[OFFW-1:0];
        req_nbytes_s  = 4'd1 << bus.req_size;
        req_span_s    = 5'(req_off_s) + 5'(req_nbytes_s);
        req_split_s   = (req_span_s > 5'(W));
        req_illegal_s = (bus.req_size == 2'd3) && (XLEN == 32);
        req_base_s    = {bus.req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_nx_s = IDLE;
                end else if (req_illegal_s) begin
                    state_nx_s = ERR;
`ifndef LOAD_ALIGN_SPLIT_EN
                end else if (req_split_s) begin
                    state_nx_s = ERR;
`endif
                end else begin
                    state_nx_s = ISSUE0;
                end
            end
`ifdef LOAD_ALIGN_SPLIT_EN
            ISSUE0: begin
                if (split_r) begin
                    state_nx_s = ISSUE1;
                end else begin
                    state_nx_s = CAPT;
                end
            end
            ISSUE1:  state_nx_s = CAPT;
`else
            ISSUE0:  state_nx_s = CAPT;
`endif
            CAPT:    state_nx_s = RESP;
            ERR:     state_nx_s = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Read strobe/address are registered from the state being entered so
    // they are high exactly during ISSUE0/ISSUE1
    always_comb begin
        mem_re_nx_s   = 1'b0;
        mem_addr_nx_s = mem_addr_r;
        if (state_nx_s == ISSUE0) begin
            mem_re_nx_s   = 1'b1;
            mem_addr_nx_s = req_base_s;
`ifdef LOAD_ALIGN_SPLIT_EN
        end else if (state_nx_s == ISSUE1) begin
            mem_re_nx_s   = 1'b1;
            mem_addr_nx_s = base_r + ADDR_WIDTH'(W);
`endif
        end else begin
            mem_re_nx_s   = 1'b0;
            mem_addr_nx_s = mem_addr_r;
        end
    end

    // Extraction: shift the (possibly two-word) window down by the byte
    // offset, keep nbytes and extend per signedness
    always_comb begin
`ifdef LOAD_ALIGN_SPLIT_EN
        if (split_r) begin
            wide_s = {bus.mem_rdata, lo_r};
        end else begin
            wide_s = {{XLEN{1'b0}}, bus.mem_rdata};
        end
`else
        wide_s = {{XLEN{1'b0}}, bus.mem_rdata};
`endif
        low_s = XLEN'(wide_s >> {off_r, 3'b000});
        case (size_r)
            2'd0: begin
                mask_s = {XLEN{1'b1}} >> (XLEN - 8);
                sign_s = low_s[7];
            end
            2'd1: begin
                mask_s = {XLEN{1'b1}} >> (XLEN - 16);
                sign_s = low_s[15];
            end
            2'd2: begin
                mask_s = {XLEN{1'b1}} >> (XLEN - 32);
                sign_s = low_s[31];
            end
            default: begin
                mask_s = {XLEN{1'b1}};
                sign_s = low_s[XLEN-1];
            end
        endcase
        if (uns_r) begin
            result_s = low_s & mask_s;
        end else if (sign_s) begin
            result_s = (low_s & mask_s) | ~mask_s;
        end else begin
            result_s = low_s & mask_s;
        end
    end

    // State and memory-read registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            mem_re_r   <= 1'b0;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            mem_re_r   <= mem_re_nx_s;
            mem_addr_r <= mem_addr_nx_s;
        end
    end

    // Request fields captured at acceptance; low word of a split captured in ISSUE1
    always_ff @(posedge clk) begin
        if (rst) begin
            off_r   <= {OFFW{1'b0}};
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
            tag_r   <= {TAG_WIDTH{1'b0}};
            err_r   <= 1'b0;
`ifdef LOAD_ALIGN_SPLIT_EN
            split_r <= 1'b0;
            base_r  <= {ADDR_WIDTH{1'b0}};
            lo_r    <= {XLEN{1'b0}};
`endif
        end else begin
            if (accept_s) begin
                off_r   <= req_off_s;
                size_r  <= bus.req_size;
                uns_r   <= bus.req_unsigned;
                tag_r   <= bus.req_tag;
                err_r   <= req_illegal_s;
`ifdef LOAD_ALIGN_SPLIT_EN
                split_r <= req_split_s;
                base_r  <= req_base_s;
`endif
            end
`ifdef LOAD_ALIGN_SPLIT_EN
            if (state_r == ISSUE1) begin
                lo_r <= bus.mem_rdata;
            end
`endif
        end
    end

    // Response registers; ERR reached with a legal size means a straddle
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= {XLEN{1'b0}};
            resp_tag_r   <= {TAG_WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
            resp_misal_r <= 1'b0;
        end else begin
            case (state_r)
                CAPT: begin
                    resp_valid_r <= 1'b1;
                    resp_data_r  <= result_s;
                    resp_tag_r   <= tag_r;
                    resp_err_r   <= 1'b0;
                    resp_misal_r <= 1'b0;
                end
                ERR: begin
                    resp_valid_r <= 1'b1;
                    resp_data_r  <= {XLEN{1'b0}};
                    resp_tag_r   <= tag_r;
                    resp_err_r   <= err_r;
                    resp_misal_r <= ~err_r;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_misal_r <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_r <= resp_valid_r;
                end
            endcase
        end
    end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential, parametrised load-data aligner between the core's memory stage and a synchronous-read data memory.
- Accepts one load request at a time: byte address, access size and signedness.
- Issues one word read, or two when the access straddles a word boundary, then extracts and zero- or sign-extends the selected bytes.
- Returns the result over a valid/ready handshake, replacing fixed-mask extraction for XLEN 32/64 and misaligned loads.

Parameters:
- XLEN, 32, data word width in bits; legal values 32 or 64; word size W = XLEN/8 bytes.
- ADDR_WIDTH, 32, byte-address width.
- TAG_WIDTH, 5, width of the opaque tag (destination register) carried from request to response.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when XLEN=64).
- req_unsigned  in  1  1=zero-extend, 0=sign-extend.
- req_tag  in  TAG_WIDTH  passed through unchanged.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_WIDTH  word-aligned read address.
- mem_rdata  in  XLEN  read data, valid exactly one cycle after mem_re.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  XLEN  aligned, extended load data.
- resp_tag  out  TAG_WIDTH  tag of the request.
- resp_err  out  1  illegal size (size 3 with XLEN=32).
- resp_misal  out  1  straddling access not supported (only without the feature macro).

Behaviour:
- Reset values: state IDLE; resp_valid=0, resp_data=0, resp_tag=0, resp_err=0, resp_misal=0, mem_re=0, mem_addr=0.
- req_ready is 0 while rst is high and 1 only in IDLE.
- Acceptance occurs when req_valid && req_ready. All request fields are latched at acceptance.
- Definitions: nbytes = 1<<req_size; off = addr mod W; base = addr with its low log2(W) bits cleared; split = (off + nbytes > W).
- States and transitions:
  - IDLE: on accept, go to ERR if the size is illegal, else to ISSUE0.
  - ISSUE0: mem_re=1, mem_addr=base. Go to ISSUE1 if split, else to CAPT.
  - ISSUE1: mem_re=1, mem_addr=base+W (wraps modulo 2^ADDR_WIDTH). Latch mem_rdata into the lo buffer. Go to CAPT.
  - CAPT: mem_re=0. Form the 2*XLEN value {mem_rdata, lo} when split, or {0, mem_rdata} when not. Shift it right by off*8, keep the low nbytes*8 bits, extend to XLEN per req_unsigned, and register the result into resp_data. Go to RESP.
  - ERR: resp_data=0, resp_err=1. Go to RESP.
  - RESP: resp_valid=1. resp_data, resp_tag and flags hold stable until resp_ready. On the handshake, clear resp_valid and flags and return to IDLE; the next request can be accepted the following cycle.
- Memory is little-endian; the byte at the lowest address goes to result bits [7:0].
- Latency, counted from the acceptance edge to resp_valid high: aligned 3 cycles, split 4 cycles, error 2 cycles.
- mem_re is never asserted outside ISSUE0/ISSUE1. At most 2 reads are issued per request.
- Reset mid-operation: the transaction is abandoned. The next cycle is IDLE with all outputs at reset values, and no response is produced.
- req_valid while busy is ignored; the requester holds its request.

Optional Feature:
- Macro LOAD_ALIGN_SPLIT_EN.
- Defined: straddling accesses are split into two reads as described above.
- Undefined: ISSUE1 does not exist. A straddling request goes IDLE->ERR with resp_misal=1, resp_data=0, resp_err=0, and no memory read. Non-straddling behaviour is unchanged.

Test Plan (XLEN=32, mem[0x100]=0x8899AABB, mem[0x104]=0x11223344):
- lb 0x101 signed -> resp_data=0xFFFFFFAA; lbu 0x101 -> 0x000000AA; one read at 0x100; resp_valid 3 cycles after accept; resp_tag echoed.
- lh 0x102 signed -> 0xFFFF8899; lw 0x104 -> 0x11223344.
- With LOAD_ALIGN_SPLIT_EN: lw 0x103 -> reads 0x100 then 0x104 on consecutive cycles; resp_data=0x22334488 at 4 cycles; lh 0x103 signed -> 0x00004488. Without the macro: lw 0x103 -> resp_misal=1, resp_data=0, mem_re never high.
- resp_ready held low 5 cycles after resp_valid -> resp_data/resp_tag stable, req_ready=0, mem_re=0; a request offered meanwhile is accepted only the cycle after the handshake.
- req_size=3 -> resp_err=1, resp_data=0, no read, resp_valid 2 cycles after accept.
- rst pulsed during ISSUE1 of a split load -> next cycle IDLE, resp_valid stays 0, req_ready=1 after rst deasserts, and a subsequent lb 0x100 returns 0xFFFFFFBB.
